raccoon_controller: RTL and testbench
=====================================

RACCOON_CONTROLLER -- requirements
Module: raccoon_controller

Interface
REQ-001 SHALL have parameter GRID_STEP, default 32, pixel distance per move.
REQ-002 SHALL have parameter MAX_X, default 608, largest legal raccoonX.
REQ-003 SHALL have parameter MAX_Y, default 448, largest legal raccoonY.
REQ-004 SHALL have parameter START_X, default 320, reset/home X.
REQ-005 SHALL have parameter START_Y, default 448, reset/home Y.
REQ-006 SHALL have parameter DEBOUNCE_CYCLES, default 250000, stable-cycle count for button acceptance; its counter width is 18 bits.
REQ-007 SHALL have parameter COOLDOWN_FRAMES, default 8, frames ignored after a move; its counter width is 4 bits.
REQ-008 SHALL have port clk  input  1  single system clock; all logic is rising-edge clocked.
REQ-009 SHALL have port rstN  input  1  asynchronous active-low reset.
REQ-010 SHALL have ports btnUp, btnDown, btnLeft, btnRight  input  1 each  raw asynchronous active-high buttons.
REQ-011 SHALL have port frameTick  input  1  one-cycle pulse, once per video frame.
REQ-012 SHALL have port raccoonX  output  10  registered X position in pixels.
REQ-013 SHALL have port raccoonY  output  10  registered Y position in pixels.
REQ-014 SHALL have port moveValid  output  1  one-cycle pulse when a position update takes effect.
REQ-015 SHALL have port moveBlocked  output  1  one-cycle pulse when a move is rejected at a boundary.
REQ-016 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-017 SHALL pass each button through a 2-flop synchronizer before any other use.
REQ-018 SHALL set a button's debounced level to its synchronized value only after that value has differed from the debounced level for DEBOUNCE_CYCLES consecutive cycles; any reversion clears that button's counter.
REQ-019 SHALL detect a press as a 0->1 transition of a debounced level; releases are ignored.
REQ-020 SHALL implement FSM states IDLE, WAIT_FRAME, MOVE, COOLDOWN.
REQ-021 SHALL in IDLE latch the direction of any press into a 2-bit pending register and go to WAIT_FRAME on the next edge.
REQ-022 SHALL resolve presses arriving in the same cycle with priority up > down > left > right.
REQ-023 SHALL drop presses arriving in WAIT_FRAME, MOVE or COOLDOWN; there is no queue.
REQ-024 SHALL in WAIT_FRAME go to MOVE on the edge where frameTick=1; a frameTick in the same cycle as the IDLE press does not count.
REQ-025 SHALL in MOVE (one cycle) compute the target: up Y-GRID_STEP, down Y+GRID_STEP, left X-GRID_STEP, right X+GRID_STEP.
REQ-026 SHALL, if the target is <0 or >MAX_X/MAX_Y, leave the position unchanged and pulse moveBlocked; otherwise register the target and pulse moveValid, on the MOVE-exit edge; no wrap-around.
REQ-027 SHALL compute the boundary check in 11-bit signed-safe arithmetic so underflow from 0 is detected.
REQ-028 SHALL on MOVE exit load the cooldown counter with COOLDOWN_FRAMES and enter COOLDOWN, or IDLE directly if COOLDOWN_FRAMES=0.
REQ-029 SHALL in COOLDOWN decrement on each frameTick and go to IDLE on the edge the counter goes 1->0.
REQ-030 SHALL assert moveValid and moveBlocked for exactly one cycle, mutually exclusive.
REQ-031 SHALL hold raccoonX/raccoonY constant except on the moveValid cycle.
REQ-032 SHALL keep debouncers running in all FSM states.

Reset
REQ-033 SHALL on rstN=0 immediately force raccoonX=START_X, raccoonY=START_Y, moveValid=0, moveBlocked=0, busy=0, state IDLE.
REQ-034 SHALL on rstN=0 clear synchronizers, debounced levels, debounce counters, pending and cooldown counters.
REQ-035 SHALL, on reset asserted mid-move, abort the move with no moveValid/moveBlocked pulse; a button held through reset release is accepted as a press only after the full debounce period.

Verification (DEBOUNCE_CYCLES=4, COOLDOWN_FRAMES=2)
REQ-036 SHALL cover: hold btnUp 10 cycles, frameTick later -> one moveValid, raccoonY 448->416, X stays 320.
REQ-037 SHALL cover: btnUp glitch of 3 cycles -> no state change, busy stays 0.
REQ-038 SHALL cover: at Y=448 press btnDown -> moveBlocked pulse, Y stays 448; at X=0 press btnLeft -> moveBlocked, X stays 0.
REQ-039 SHALL cover: btnLeft and btnUp debounce-rise in the same cycle -> only the up move occurs.
REQ-040 SHALL cover: second btnRight press during COOLDOWN -> dropped; busy falls on the 2nd frameTick after the move.
REQ-041 SHALL cover: rstN pulsed low in WAIT_FRAME -> outputs return to 320/448 asynchronously, no pulse, state IDLE.

Source files
------------

// File: rtl/raccoon_controller.sv
// Grid-stepping sprite controller: four debounced buttons request one move per
// video frame, with boundary rejection and a post-move cooldown in frames.
module raccoon_controller #(
   parameter int GRID_STEP       = 32,
   parameter int MAX_X           = 608,
   parameter int MAX_Y           = 448,
   parameter int START_X         = 320,
   parameter int START_Y         = 448,
   parameter int DEBOUNCE_CYCLES = 250000,
   parameter int COOLDOWN_FRAMES = 8
) (
   input  logic       clk,
   input  logic       rstN,
   input  logic       btnUp,
   input  logic       btnDown,
   input  logic       btnLeft,
   input  logic       btnRight,
   input  logic       frameTick,
   output logic [9:0] raccoonX,
   output logic [9:0] raccoonY,
   output logic       moveValid,
   output logic       moveBlocked,
   output logic       busy
);

   typedef enum logic [1:0] {IDLE, WAIT_FRAME, MOVE, COOLDOWN} state_t;

   localparam logic [17:0]        DB_LAST = 18'(DEBOUNCE_CYCLES - 1);
   localparam logic signed [10:0] STEP_S  = 11'(GRID_STEP);
   localparam logic signed [10:0] MAX_X_S = 11'(MAX_X);
   localparam logic signed [10:0] MAX_Y_S = 11'(MAX_Y);

   // Bit order doubles as the direction code: 0 up, 1 down, 2 left, 3 right.
   logic [3:0] btn_raw;
   logic [3:0] press;
   assign btn_raw = {btnRight, btnLeft, btnDown, btnUp};

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_btn
         logic        sync1_reg, sync2_reg, deb_reg, deb_d_reg;
         logic [17:0] cnt_reg;

         always_ff @(posedge clk or negedge rstN) begin
            if (!rstN) begin
               sync1_reg <= 1'b0;
               sync2_reg <= 1'b0;
               deb_reg   <= 1'b0;
               deb_d_reg <= 1'b0;
               cnt_reg   <= '0;
            end else begin
               sync1_reg <= btn_raw[gi];
               sync2_reg <= sync1_reg;
               deb_d_reg <= deb_reg;
               if (sync2_reg != deb_reg) begin
                  if (cnt_reg == DB_LAST) begin
                     deb_reg <= sync2_reg;
                     cnt_reg <= '0;
                  end else begin
                     cnt_reg <= cnt_reg + 18'd1;
                  end
               end else begin
                  cnt_reg <= '0;
               end
            end
         end

         assign press[gi] = deb_reg & ~deb_d_reg;
      end
   endgenerate

   state_t     state_reg;
   logic [1:0] pending_reg;
   logic [3:0] cool_reg;
   logic [9:0] x_reg, y_reg;
   logic       valid_reg, blocked_reg, busy_reg;

   logic [1:0]        pend_next;
   logic signed [10:0] tgt_x, tgt_y;
   logic              tgt_blocked;

   always_comb begin
      pend_next = 2'd3;
      if (press[0])      pend_next = 2'd0;
      else if (press[1]) pend_next = 2'd1;
      else if (press[2]) pend_next = 2'd2;
   end

   // One spare bit keeps 0 - GRID_STEP negative instead of wrapping.
   always_comb begin
      tgt_x = $signed({1'b0, x_reg});
      tgt_y = $signed({1'b0, y_reg});
      case (pending_reg)
         2'd0:    tgt_y = $signed({1'b0, y_reg}) - STEP_S;
         2'd1:    tgt_y = $signed({1'b0, y_reg}) + STEP_S;
         2'd2:    tgt_x = $signed({1'b0, x_reg}) - STEP_S;
         default: tgt_x = $signed({1'b0, x_reg}) + STEP_S;
      endcase
      tgt_blocked = (tgt_x < 0) || (tgt_x > MAX_X_S) ||
                    (tgt_y < 0) || (tgt_y > MAX_Y_S);
   end

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         state_reg   <= IDLE;
         pending_reg <= 2'd0;
         cool_reg    <= 4'd0;
         x_reg       <= 10'(START_X);
         y_reg       <= 10'(START_Y);
         valid_reg   <= 1'b0;
         blocked_reg <= 1'b0;
         busy_reg    <= 1'b0;
      end else begin
         valid_reg   <= 1'b0;
         blocked_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (|press) begin
                  pending_reg <= pend_next;
                  state_reg   <= WAIT_FRAME;
                  busy_reg    <= 1'b1;
               end
            end
            WAIT_FRAME: begin
               if (frameTick) state_reg <= MOVE;
            end
            MOVE: begin
               if (tgt_blocked) begin
                  blocked_reg <= 1'b1;
               end else begin
                  valid_reg <= 1'b1;
                  x_reg     <= tgt_x[9:0];
                  y_reg     <= tgt_y[9:0];
               end
               cool_reg <= 4'(COOLDOWN_FRAMES);
               if (COOLDOWN_FRAMES == 0) begin
                  state_reg <= IDLE;
                  busy_reg  <= 1'b0;
               end else begin
                  state_reg <= COOLDOWN;
               end
            end
            COOLDOWN: begin
               if (frameTick) begin
                  cool_reg <= cool_reg - 4'd1;
                  if (cool_reg == 4'd1) begin
                     state_reg <= IDLE;
                     busy_reg  <= 1'b0;
                  end
               end
            end
            default: begin
               state_reg <= IDLE;
               busy_reg  <= 1'b0;
            end
         endcase
      end
   end

   assign raccoonX    = x_reg;
   assign raccoonY    = y_reg;
   assign moveValid   = valid_reg;
   assign moveBlocked = blocked_reg;
   assign busy        = busy_reg;

endmodule

// File: tb/tb_raccoon_controller.sv
// Directed bench for raccoon_controller with a short debounce and 2-frame cooldown.
module tb_raccoon_controller;

   logic       clk = 1'b0;
   logic       rstN = 1'b0;
   logic       btnUp = 1'b0, btnDown = 1'b0, btnLeft = 1'b0, btnRight = 1'b0;
   logic       frameTick = 1'b0;
   logic [9:0] raccoonX, raccoonY;
   logic       moveValid, moveBlocked, busy;

   int checks = 0;
   int passed = 0;
   int mv_cnt = 0, mb_cnt = 0, both_cnt = 0;

   raccoon_controller #(
      .GRID_STEP(32), .MAX_X(608), .MAX_Y(448), .START_X(320), .START_Y(448),
      .DEBOUNCE_CYCLES(4), .COOLDOWN_FRAMES(2)
   ) dut (
      .clk(clk), .rstN(rstN),
      .btnUp(btnUp), .btnDown(btnDown), .btnLeft(btnLeft), .btnRight(btnRight),
      .frameTick(frameTick),
      .raccoonX(raccoonX), .raccoonY(raccoonY),
      .moveValid(moveValid), .moveBlocked(moveBlocked), .busy(busy)
   );

   always #5 clk = ~clk;

   // Pulse tally, sampled just after each rising edge.
   always @(posedge clk) begin
      #1;
      if (moveValid) mv_cnt++;
      if (moveBlocked) mb_cnt++;
      if (moveValid && moveBlocked) both_cnt++;
   end

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic set_btn(input int idx, input logic v);
      case (idx)
         0: btnUp = v;
         1: btnDown = v;
         2: btnLeft = v;
         default: btnRight = v;
      endcase
   endtask

   task automatic pulse_tick();
      frameTick = 1'b1;
      step(1);
      frameTick = 1'b0;
      step(2);
   endtask

   // Full press -> frame -> move -> cooldown cycle, ending back in IDLE.
   task automatic do_move(input int idx);
      set_btn(idx, 1'b1);
      step(8);
      set_btn(idx, 1'b0);
      step(4);
      pulse_tick();
      pulse_tick();
      pulse_tick();
      step(6);
   endtask

   task automatic test_reset();
      rstN = 1'b0;
      step(2);
      checks++; if (raccoonX !== 10'd320) $display("FAIL reset_x got %0d want 320", raccoonX); else passed++;
      checks++; if (raccoonY !== 10'd448) $display("FAIL reset_y got %0d want 448", raccoonY); else passed++;
      checks++; if (moveValid !== 1'b0) $display("FAIL reset_mv got %b want 0", moveValid); else passed++;
      checks++; if (moveBlocked !== 1'b0) $display("FAIL reset_mb got %b want 0", moveBlocked); else passed++;
      checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passed++;
      rstN = 1'b1;
      step(3);
      $display("reset: X=%0d Y=%0d busy=%b", raccoonX, raccoonY, busy);
   endtask

   task automatic test_up_move();
      mv_cnt = 0; mb_cnt = 0;
      btnUp = 1'b1;
      step(10);
      btnUp = 1'b0;
      step(3);
      checks++; if (busy !== 1'b1) $display("FAIL up_wait_busy got %b want 1", busy); else passed++;
      checks++; if (raccoonY !== 10'd448) $display("FAIL up_premove_y got %0d want 448", raccoonY); else passed++;
      pulse_tick();
      step(2);
      checks++; if (mv_cnt !== 1) $display("FAIL up_mv_count got %0d want 1", mv_cnt); else passed++;
      checks++; if (raccoonY !== 10'd416) $display("FAIL up_y got %0d want 416", raccoonY); else passed++;
      checks++; if (raccoonX !== 10'd320) $display("FAIL up_x got %0d want 320", raccoonX); else passed++;
      pulse_tick();
      checks++; if (busy !== 1'b1) $display("FAIL up_cool1_busy got %b want 1", busy); else passed++;
      pulse_tick();
      checks++; if (busy !== 1'b0) $display("FAIL up_cool2_busy got %b want 0", busy); else passed++;
      $display("up move: X=%0d Y=%0d moves=%0d", raccoonX, raccoonY, mv_cnt);
   endtask

   task automatic test_glitch();
      int busy_seen;
      busy_seen = 0;
      mv_cnt = 0;
      step(8);
      btnUp = 1'b1; step(3); btnUp = 1'b0; step(1);
      btnUp = 1'b1; step(3); btnUp = 1'b0;
      for (int i = 0; i < 16; i++) begin
         step(1);
         if (busy) busy_seen++;
      end
      checks++; if (busy_seen !== 0) $display("FAIL glitch_busy got %0d busy cycles want 0", busy_seen); else passed++;
      checks++; if (raccoonY !== 10'd416) $display("FAIL glitch_y got %0d want 416", raccoonY); else passed++;
      checks++; if (mv_cnt !== 0) $display("FAIL glitch_mv got %0d want 0", mv_cnt); else passed++;
      $display("glitch: busy_cycles=%0d Y=%0d", busy_seen, raccoonY);
   endtask

   task automatic test_boundary();
      do_move(1);
      checks++; if (raccoonY !== 10'd448) $display("FAIL down_y got %0d want 448", raccoonY); else passed++;
      mv_cnt = 0; mb_cnt = 0; both_cnt = 0;
      do_move(1);
      checks++; if (mb_cnt !== 1) $display("FAIL down_block_count got %0d want 1", mb_cnt); else passed++;
      checks++; if (mv_cnt !== 0) $display("FAIL down_block_mv got %0d want 0", mv_cnt); else passed++;
      checks++; if (raccoonY !== 10'd448) $display("FAIL down_block_y got %0d want 448", raccoonY); else passed++;
      $display("bottom edge: Y=%0d blocked=%0d", raccoonY, mb_cnt);
      for (int i = 0; i < 10; i++) do_move(2);
      checks++; if (raccoonX !== 10'd0) $display("FAIL left_walk_x got %0d want 0", raccoonX); else passed++;
      mv_cnt = 0; mb_cnt = 0;
      do_move(2);
      checks++; if (mb_cnt !== 1) $display("FAIL left_block_count got %0d want 1", mb_cnt); else passed++;
      checks++; if (raccoonX !== 10'd0) $display("FAIL left_block_x got %0d want 0", raccoonX); else passed++;
      checks++; if (both_cnt !== 0) $display("FAIL pulse_exclusive got %0d overlaps want 0", both_cnt); else passed++;
      $display("left edge: X=%0d blocked=%0d", raccoonX, mb_cnt);
   endtask

   task automatic test_priority();
      mv_cnt = 0; mb_cnt = 0;
      btnLeft = 1'b1; btnUp = 1'b1;
      step(8);
      btnLeft = 1'b0; btnUp = 1'b0;
      step(4);
      pulse_tick(); pulse_tick(); pulse_tick();
      step(10);
      checks++; if (mv_cnt !== 1) $display("FAIL prio_mv got %0d want 1", mv_cnt); else passed++;
      checks++; if (raccoonY !== 10'd416) $display("FAIL prio_y got %0d want 416", raccoonY); else passed++;
      checks++; if (raccoonX !== 10'd0) $display("FAIL prio_x got %0d want 0", raccoonX); else passed++;
      $display("priority up/left: X=%0d Y=%0d", raccoonX, raccoonY);
   endtask

   task automatic test_cooldown_drop();
      mv_cnt = 0;
      btnRight = 1'b1; step(8); btnRight = 1'b0; step(4);
      pulse_tick();
      checks++; if (raccoonX !== 10'd32) $display("FAIL cool_first_x got %0d want 32", raccoonX); else passed++;
      btnRight = 1'b1; step(8); btnRight = 1'b0; step(8);
      pulse_tick();
      checks++; if (busy !== 1'b1) $display("FAIL cool_tick1_busy got %b want 1", busy); else passed++;
      pulse_tick();
      checks++; if (busy !== 1'b0) $display("FAIL cool_tick2_busy got %b want 0", busy); else passed++;
      step(10);
      checks++; if (busy !== 1'b0) $display("FAIL cool_dropped_busy got %b want 0", busy); else passed++;
      pulse_tick();
      step(4);
      checks++; if (raccoonX !== 10'd32) $display("FAIL cool_drop_x got %0d want 32", raccoonX); else passed++;
      checks++; if (mv_cnt !== 1) $display("FAIL cool_drop_mv got %0d want 1", mv_cnt); else passed++;
      $display("cooldown drop: X=%0d moves=%0d", raccoonX, mv_cnt);
   endtask

   task automatic test_reset_midmove();
      btnUp = 1'b1; step(8); btnUp = 1'b0; step(2);
      checks++; if (busy !== 1'b1) $display("FAIL rst_pre_busy got %b want 1", busy); else passed++;
      mv_cnt = 0; mb_cnt = 0;
      #2 rstN = 1'b0;
      #1;
      checks++; if (raccoonX !== 10'd320) $display("FAIL rst_async_x got %0d want 320", raccoonX); else passed++;
      checks++; if (raccoonY !== 10'd448) $display("FAIL rst_async_y got %0d want 448", raccoonY); else passed++;
      checks++; if (busy !== 1'b0) $display("FAIL rst_async_busy got %b want 0", busy); else passed++;
      frameTick = 1'b1;
      step(2);
      frameTick = 1'b0;
      rstN = 1'b1;
      step(12);
      checks++; if ((mv_cnt + mb_cnt) !== 0) $display("FAIL rst_no_pulse got %0d pulses want 0", mv_cnt + mb_cnt); else passed++;
      checks++; if (busy !== 1'b0) $display("FAIL rst_idle_busy got %b want 0", busy); else passed++;
      checks++; if (raccoonY !== 10'd448) $display("FAIL rst_hold_y got %0d want 448", raccoonY); else passed++;
      $display("reset mid-move: X=%0d Y=%0d pulses=%0d", raccoonX, raccoonY, mv_cnt + mb_cnt);
      // Button held across reset release must wait out the whole debounce.
      rstN = 1'b0;
      btnUp = 1'b1;
      step(2);
      rstN = 1'b1;
      step(3);
      checks++; if (busy !== 1'b0) $display("FAIL held_early_busy got %b want 0", busy); else passed++;
      step(7);
      checks++; if (busy !== 1'b1) $display("FAIL held_late_busy got %b want 1", busy); else passed++;
      btnUp = 1'b0;
      $display("held through reset: busy=%b", busy);
   endtask

   initial begin
      step(1);
      test_reset();
      test_up_move();
      test_glitch();
      test_boundary();
      test_priority();
      test_cooldown_drop();
      test_reset_midmove();
      step(2);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
